// File: rtl/plotter_pkg.sv
// Shared definitions for the plotter axis drivers so every axis instance
// agrees on state encoding, direction polarity and default timing.
package plotter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } stepper_state_t;

    // Level driven on dir for a move toward increasing position.
    localparam logic DIR_POSITIVE = 1'b1;

    localparam int COUNT_WIDTH      = 16;
    localparam int PERIOD_WIDTH     = 20;
    localparam int PULSE_WIDTH      = 50;
    localparam int DIR_SETUP_CYCLES = 100;
    localparam int HOLD_CYCLES      = 1000;

endpackage

// File: rtl/stepper_axis_driver_cycle_timer.sv
// Loadable down-counter with a zero flag. The count stops at zero rather
// than wrapping, so an unattended timer simply stays expired.
module cycle_timer #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load has priority over counting; decrement saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/stepper_axis_driver.sv
// Step/direction pulse generator for one plotter axis. Accepts a signed
// relative move over valid/ready, emits |steps| pulses at the commanded
// period, and keeps the driver enabled for a hold time after each move.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE, and operands are
// captured on that edge so the controller may change them afterwards.
module stepper_axis_driver #(
    parameter int COUNT_WIDTH      = plotter_pkg::COUNT_WIDTH,
    parameter int PERIOD_WIDTH     = plotter_pkg::PERIOD_WIDTH,
    parameter int PULSE_WIDTH      = plotter_pkg::PULSE_WIDTH,
    parameter int DIR_SETUP_CYCLES = plotter_pkg::DIR_SETUP_CYCLES,
    parameter int HOLD_CYCLES      = plotter_pkg::HOLD_CYCLES
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [COUNT_WIDTH-1:0]       cmd_steps,
    input  logic [PERIOD_WIDTH-1:0]      cmd_period,
    output logic                         done,
    output logic                         busy,
    output logic                         step_out,
    output logic                         dir,
    output logic                         n_en,
    output plotter_pkg::stepper_state_t  dbg_state_o
);

    import plotter_pkg::*;

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [PERIOD_WIDTH-1:0] MIN_PERIOD = PERIOD_WIDTH'(2 * PULSE_WIDTH);
    localparam logic [PERIOD_WIDTH-1:0] SETUP_LOAD = PERIOD_WIDTH'(DIR_SETUP_CYCLES);
    localparam logic [PERIOD_WIDTH-1:0] HIGH_LOAD  = PERIOD_WIDTH'(PULSE_WIDTH - 1);
    localparam logic [PERIOD_WIDTH-1:0] LOW_ADJ    = PERIOD_WIDTH'(PULSE_WIDTH + 1);
    localparam logic [HOLD_W-1:0]       HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);

    stepper_state_t           state_q, state_d;
    logic [COUNT_WIDTH-1:0]   remaining_q, remaining_d;
    logic [PERIOD_WIDTH-1:0]  period_q, period_d;
    logic                     dir_q, dir_d;
    logic                     n_en_q, n_en_d;
    logic                     done_q, done_d;

    logic                     ph_load, ph_en, ph_zero;
    logic [PERIOD_WIDTH-1:0]  ph_val;
    logic                     hold_load, hold_en, hold_zero;

    logic [COUNT_WIDTH-1:0]   steps_abs;
    logic                     steps_nz;
    logic [PERIOD_WIDTH-1:0]  period_clamped;

    // Magnitude in unsigned form so the most negative count maps to 2^(W-1).
    assign steps_abs      = cmd_steps[COUNT_WIDTH-1] ? (~cmd_steps + COUNT_WIDTH'(1)) : cmd_steps;
    assign steps_nz       = (cmd_steps != '0);
    assign period_clamped = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;

    // Phase timer: each state lasts (load value + 1) cycles.
    cycle_timer #(.WIDTH(PERIOD_WIDTH)) u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ph_load),
        .load_val_i (ph_val),
        .en_i       (ph_en),
        .zero_o     (ph_zero)
    );

    // Hold timer: counts idle cycles with the driver still enabled.
    cycle_timer #(.WIDTH(HOLD_W)) u_hold_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (hold_load),
        .load_val_i (HOLD_LOAD),
        .en_i       (hold_en),
        .zero_o     (hold_zero)
    );

    // Next-state, operand capture and timer control.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        period_d    = period_q;
        dir_d       = dir_q;
        n_en_d      = n_en_q;
        done_d      = 1'b0;
        ph_load     = 1'b0;
        ph_val      = '0;
        ph_en       = 1'b0;
        hold_load   = 1'b0;
        hold_en     = 1'b0;
        case (state_q)
            IDLE: begin
                hold_en = ~n_en_q;
                if (~n_en_q && hold_zero) begin
                    n_en_d = 1'b1;
                end
                if (cmd_valid) begin
                    if (steps_nz) begin
                        // A new move overrides any release due this cycle.
                        state_d     = SETUP;
                        remaining_d = steps_abs;
                        period_d    = period_clamped;
                        dir_d       = cmd_steps[COUNT_WIDTH-1] ? ~DIR_POSITIVE : DIR_POSITIVE;
                        n_en_d      = 1'b0;
                        ph_load     = 1'b1;
                        ph_val      = SETUP_LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (ph_zero) begin
                    state_d = HIGH;
                    ph_load = 1'b1;
                    ph_val  = HIGH_LOAD;
                end else begin
                    ph_en = 1'b1;
                end
            end
            HIGH: begin
                if (ph_zero) begin
                    state_d     = LOW;
                    remaining_d = remaining_q - COUNT_WIDTH'(1);
                    ph_load     = 1'b1;
                    ph_val      = period_q - LOW_ADJ;
                end else begin
                    ph_en = 1'b1;
                end
            end
            LOW: begin
                if (ph_zero) begin
                    if (remaining_q == '0) begin
                        state_d   = IDLE;
                        done_d    = 1'b1;
                        hold_load = 1'b1;
                    end else begin
                        state_d = HIGH;
                        ph_load = 1'b1;
                        ph_val  = HIGH_LOAD;
                    end
                end else begin
                    ph_en = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset releases the driver immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            period_q    <= '0;
            dir_q       <= 1'b0;
            n_en_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            period_q    <= period_d;
            dir_q       <= dir_d;
            n_en_q      <= n_en_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign step_out    = (state_q == HIGH);
    assign dir         = dir_q;
    assign n_en        = n_en_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_stepper_axis_driver.sv
// Directed bench for stepper_axis_driver: a default-width axis plus a
// 4-bit-count axis for the most-negative-count case.
module tb_stepper_axis_driver;
  import plotter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready, done, busy, step_out, dir, n_en;
  logic [15:0] cmd_steps;
  logic [19:0] cmd_period;
  stepper_state_t dbg_state;

  logic        c4_valid, c4_ready, c4_done, c4_busy, c4_step, c4_dir, c4_nen;
  logic [3:0]  c4_steps;
  logic [19:0] c4_period;
  stepper_state_t c4_state;

  stepper_axis_driver dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_period(cmd_period), .done(done), .busy(busy),
    .step_out(step_out), .dir(dir), .n_en(n_en), .dbg_state_o(dbg_state)
  );

  stepper_axis_driver #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .cmd_valid(c4_valid), .cmd_ready(c4_ready),
    .cmd_steps(c4_steps), .cmd_period(c4_period), .done(c4_done), .busy(c4_busy),
    .step_out(c4_step), .dir(c4_dir), .n_en(c4_nen), .dbg_state_o(c4_state)
  );

  int n_checks = 0;
  int n_fail = 0;
  int unsigned cyc = 0;
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor / scoreboard state for the default axis.
  int unsigned acc_cyc = 0, last_rise = 0, exp_period = 100;
  bit          have_rise = 0, pend_acc = 0, acc_zero = 0, watch_nen = 0;
  int          pulse_cnt = 0, nen_high_cnt = 0;
  logic        exp_dir = 1'b0, nen_at_acc = 1'b1, dir_at_acc = 1'b0, prev_step = 1'b0;
  logic [31:0] exp_cnt;

  always @(negedge clk) begin
    if (reset) begin
      pulse_cnt = 0;
      have_rise = 0;
      pend_acc  = 0;
      prev_step = 1'b0;
    end else begin
      if (pend_acc && !acc_zero) begin
        check("nen_after_accept", n_en, 0);
        check("busy_after_accept", busy, 1);
      end
      pend_acc = 0;
      if (watch_nen && n_en) nen_high_cnt++;
      if (step_out && !prev_step) begin
        pulse_cnt++;
        if (!have_rise) check("first_rise_latency", cyc - acc_cyc, DIR_SETUP_CYCLES + 1);
        else check("rise_spacing", cyc - last_rise, exp_period);
        check("dir_at_rise", dir, exp_dir);
        check("ready_low_while_busy", cmd_ready, 0);
        last_rise = cyc;
        have_rise = 1;
      end
      if (!step_out && prev_step) check("pulse_high_width", cyc - last_rise, PULSE_WIDTH);
      prev_step = step_out;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", done, 0);
        end else begin
          exp_cnt = exp_q.pop_front();
          check("pulse_count", pulse_cnt, exp_cnt);
          check("busy_at_done", busy, 0);
          if (acc_zero) begin
            check("zero_done_latency", cyc - acc_cyc, 0);
            check("zero_dir_kept", dir, dir_at_acc);
            check("zero_nen_kept", n_en, nen_at_acc);
          end else begin
            check("done_after_last_low", cyc - last_rise, exp_period);
          end
        end
        pulse_cnt = 0;
        have_rise = 0;
      end
      if (cmd_valid && cmd_ready) begin
        acc_cyc    = cyc + 1;
        pend_acc   = 1;
        acc_zero   = (cmd_steps == 16'd0);
        nen_at_acc = n_en;
        dir_at_acc = dir;
        exp_period = (cmd_period < 20'd100) ? 100 : cmd_period;
        if (cmd_steps != 16'd0) exp_dir = ~cmd_steps[15];
      end
    end
  end

  // Pulse counter for the 4-bit axis.
  int   p4_cnt = 0;
  logic p4_prev = 1'b0;
  always @(negedge clk) begin
    if (c4_step && !p4_prev) begin
      p4_cnt++;
      check("dut4_dir_at_rise", c4_dir, 0);
    end
    p4_prev = c4_step;
  end

  task automatic send(input int steps, input int period);
    @(posedge clk);
    #1;
    cmd_valid  = 1'b1;
    cmd_steps  = 16'(steps);
    cmd_period = 20'(period);
    exp_q.push_back((steps < 0) ? 32'(-steps) : 32'(steps));
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    check("accept_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    cmd_steps  = 16'($urandom);
    cmd_period = 20'($urandom_range(1, 5000));
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_seen", done, 1);
  endtask

  // Called on the done cycle: counts idle cycles with n_en still low.
  task automatic measure_hold();
    int cnt;
    cnt = 1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (n_en) break;
      cnt++;
    end
    check("hold_cycles", cnt, HOLD_CYCLES);
  endtask

  int nen_base;

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_steps = '0; cmd_period = '0;
    c4_valid = 1'b0; c4_steps = '0; c4_period = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_step_out", step_out, 0);
    check("rst_dir", dir, 0);
    check("rst_n_en", n_en, 1);
    check("rst_state", dbg_state, IDLE);
    @(posedge clk);
    #1 reset = 1'b0;

    // +3 steps at period 200, then the enable hold time.
    send(3, 200);
    wait_done(5000);
    measure_hold();

    // -5 steps with a period below the minimum.
    send(-5, 10);
    wait_done(5000);

    // Zero-step command during the hold.
    send(0, 77);
    wait_done(10);

    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (n_en) break;
    end
    check("nen_released", n_en, 1);

    // New move issued mid-hold keeps the driver enabled throughout.
    send(2, 100);
    wait_done(3000);
    nen_base = nen_high_cnt;
    watch_nen = 1;
    repeat (498) @(negedge clk);
    send(2, 150);
    wait_done(3000);
    watch_nen = 0;
    check("nen_glitch_cycles", nen_high_cnt - nen_base, 0);
    measure_hold();

    // Reset during the second HIGH of a +10 move.
    send(10, 100);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      #1;
      if (pulse_cnt == 2 && step_out) break;
    end
    check("second_pulse_reached", step_out, 1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_step_out", step_out, 0);
    check("async_rst_n_en", n_en, 1);
    check("async_rst_state", dbg_state, IDLE);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    repeat (3) @(negedge clk);
    check("rst_no_done", done, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_n_en", n_en, 1);
    check("post_rst_busy", busy, 0);

    // Most negative count on the 4-bit axis: -8 gives 8 pulses.
    @(posedge clk);
    #1;
    c4_valid = 1'b1; c4_steps = 4'b1000; c4_period = 20'd100;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (c4_ready) break;
    end
    @(posedge clk);
    #1;
    c4_valid = 1'b0; c4_steps = 4'd3; c4_period = 20'd7;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (c4_done) break;
    end
    check("dut4_done_seen", c4_done, 1);
    check("dut4_pulse_count", p4_cnt, 8);
    check("dut4_busy_at_done", c4_busy, 0);
    check("dut4_dir", c4_dir, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
